// File: rtl/tuart_rx_cfg_if.sv
// tuart_rx_cfg_if: receive-side bus of tuart_rx_cfg (word, strobe, error flags, busy).
// master = the receiver that drives it, slave = the consumer (command decoder).
interface tuart_rx_cfg_if #(
  parameter int WORD_BITS = 8
);
  logic [WORD_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 parity_err_o;
  logic                 frame_err_o;
  logic                 break_o;
  logic                 busy_o;

  modport master (
    output data_o, valid_o, parity_err_o, frame_err_o, break_o, busy_o
  );

  modport slave (
    input data_o, valid_o, parity_err_o, frame_err_o, break_o, busy_o
  );
endinterface

// File: rtl/tuart_rx_cfg.sv
// tuart_rx_cfg: configurable UART receiver (word length, parity, stop bits, error reporting).
// Build option TUART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
module tuart_rx_cfg #(
  parameter int WORD_BITS   = 8,
  parameter int CLK_PER_BIT = 868,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_i,
  input  logic           rst_in,
  input  logic           rx_i,
  tuart_rx_cfg_if.master rx_bus
);
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int IW = $clog2(WORD_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(WORD_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAIT_HIGH
  } state_t;

  state_t                 r_state, w_next, w_take_st;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic [WORD_BITS-1:0]   r_shift, r_data;
  logic                   r_par_bit, r_ferr_acc, r_last_stop;
  logic                   r_valid, r_perr, r_ferr, r_brk;
  logic                   w_rx_s, w_counting, w_mid, w_take, w_bit;
  logic                   w_ferr_fin, w_last_fin, w_perr, w_brk;

  assign w_rx_s     = r_sync[SYNC_STAGES-1];
  assign w_counting = (r_state == S_START) || (r_state == S_DATA) ||
                      (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_mid      = ((r_state == S_START) && (r_cnt == CNT_HALF)) ||
                      (w_counting && (r_state != S_START) && (r_cnt == CNT_LAST));

  // Sample decisions land one cycle after the nominal point in the majority build;
  // w_take/w_take_st name the bit being decided so both builds share the datapath.
`ifdef TUART_RX_MAJORITY_EN
  logic   r_prev, r_s_m1, r_s_0, r_pend;
  state_t r_pend_st;

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      r_prev    <= 1'b1;
      r_s_m1    <= 1'b1;
      r_s_0     <= 1'b1;
      r_pend    <= 1'b0;
      r_pend_st <= S_IDLE;
    end else begin
      r_prev <= w_rx_s;
      r_pend <= w_mid;
      if (w_mid) begin
        r_s_m1    <= r_prev;
        r_s_0     <= w_rx_s;
        r_pend_st <= r_state;
      end
    end
  end

  assign w_take    = r_pend;
  assign w_take_st = r_pend_st;
  assign w_bit     = (r_s_m1 & r_s_0) | (r_s_m1 & w_rx_s) | (r_s_0 & w_rx_s);
`else
  assign w_take    = w_mid;
  assign w_take_st = r_state;
  assign w_bit     = w_rx_s;
`endif

  assign w_ferr_fin = r_ferr_acc | (w_take && (w_take_st == S_STOP) && !w_bit);
  assign w_last_fin = (w_take && (w_take_st == S_STOP)) ? w_bit : r_last_stop;
  assign w_brk      = w_ferr_fin && (r_shift == '0) && ((PARITY == 0) || !r_par_bit);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_perr = 1'b0;
    if (PARITY == 1)      w_perr = ^{r_shift, r_par_bit};
    else if (PARITY == 2) w_perr = ~(^{r_shift, r_par_bit});
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (!w_rx_s) w_next = S_START;
      S_START:     if (w_mid) w_next = S_DATA;
      S_DATA:      if (w_mid && (r_idx == IDX_LAST)) w_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY:    if (w_mid) w_next = S_STOP;
      S_STOP:      if (w_mid && (r_idx == STOP_LAST)) w_next = S_DONE;
      S_DONE:      w_next = w_last_fin ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (w_rx_s) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    // A start bit that reads high is a glitch: drop it silently.
    if (w_take && (w_take_st == S_START) && w_bit) w_next = S_IDLE;
  end

  // NOTE: state uses non-blocking assignments and a reset tested inside the clocked block.
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      r_sync      <= '1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_par_bit   <= 1'b0;
      r_ferr_acc  <= 1'b0;
      r_last_stop <= 1'b1;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_brk       <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], rx_i};
      r_state <= w_next;
      r_valid <= (r_state == S_DONE);

      if (w_counting && !w_mid) r_cnt <= r_cnt + 1'b1;
      else                      r_cnt <= '0;

      if (r_state == S_IDLE) begin
        r_idx       <= '0;
        r_ferr_acc  <= 1'b0;
        r_last_stop <= 1'b1;
      end else if (w_mid && ((r_state == S_DATA) || (r_state == S_STOP))) begin
        if (((r_state == S_DATA) && (r_idx == IDX_LAST)) ||
            ((r_state == S_STOP) && (r_idx == STOP_LAST)))
          r_idx <= '0;
        else
          r_idx <= r_idx + 1'b1;
      end

      if (w_take) begin
        case (w_take_st)
          S_DATA:   r_shift   <= {w_bit, r_shift[WORD_BITS-1:1]};
          S_PARITY: r_par_bit <= w_bit;
          S_STOP: begin
            if (!w_bit) r_ferr_acc <= 1'b1;
            r_last_stop <= w_bit;
          end
          default: ;
        endcase
      end

      if (r_state == S_DONE) begin
        r_data <= r_shift;
        r_perr <= w_perr;
        r_ferr <= w_ferr_fin;
        r_brk  <= w_brk;
      end
    end
  end

  assign rx_bus.data_o       = r_data;
  assign rx_bus.valid_o      = r_valid;
  assign rx_bus.parity_err_o = r_perr;
  assign rx_bus.frame_err_o  = r_ferr;
  assign rx_bus.break_o      = r_brk;
  assign rx_bus.busy_o       = (r_state != S_IDLE);
endmodule

// File: doc/tuart_rx_cfg.md
Name: tuart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 tuart_rx. It adds configurable word length, parity, stop-bit count, input synchroniser depth, and framing/parity/break error reporting. It sits between the external rx pin and the command decoder of the logic-analyser core, and delivers one word per frame as a single-cycle strobe.

Parameters:
WORD_BITS, 8, data bits per frame (5..9), LSB first
CLK_PER_BIT, 868, clk_i cycles per bit period (>= 4)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits (1 or 2)
SYNC_STAGES, 2, rx input synchroniser flops (>= 2)

Ports:
clk_i  in  1  system clock
rst_in  in  1  synchronous, active-low reset
rx_i  in  1  asynchronous serial line, idle high
data_o  out  WORD_BITS  received word, held until the next valid_o
valid_o  out  1  one-cycle strobe: data_o and the error flags are valid
parity_err_o  out  1  parity mismatch, qualified by valid_o
frame_err_o  out  1  a stop bit was sampled 0, qualified by valid_o
break_o  out  1  data all zero and stop 0, qualified by valid_o
busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst_in = 0 at a clk_i edge): synchroniser flops = 1, FSM = IDLE, counters = 0, data_o = 0, all strobes and flags = 0, busy_o = 0. Reset mid-frame abandons the frame with no valid_o.
- rx_i passes through SYNC_STAGES flops to give rx_s. All logic uses rx_s only.
- Bit counter cnt counts 0..CLK_PER_BIT-1. Bit index counter idx counts 0..WORD_BITS-1.
- FSM states and transitions:
  - IDLE: rx_s = 0 → START, cnt = 0.
  - START: at cnt = CLK_PER_BIT/2-1, sample. Sample 1 → IDLE (glitch, nothing reported). Sample 0 → DATA, cnt = 0, idx = 0.
  - DATA: at cnt = CLK_PER_BIT-1, sample into shift register bit idx. After idx = WORD_BITS-1 → PARITY if PARITY != 0, else STOP.
  - PARITY: sample one bit. Even parity: err = XOR(data, bit) != 0. Odd parity: err = XOR(data, bit) != 1.
  - STOP: sample STOP_BITS bits. Any 0 sets the frame error. After the last stop sample → DONE.
  - DONE (one cycle): valid_o = 1; data_o, parity_err_o, frame_err_o, break_o updated. Next state is IDLE if the last stop sample was 1, else WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s = 1, then IDLE. This prevents a break or low line from retriggering.
- Latency: valid_o is high exactly CLK_PER_BIT/2 + (WORD_BITS + (PARITY != 0) + STOP_BITS)*CLK_PER_BIT + 1 cycles after the first edge where rx_s = 0 in IDLE.
- Back-to-back frames: because the last stop bit is sampled at mid-bit, the next start edge is detected from IDLE with no lost frame.
- Error flags are registered alongside data_o and are only meaningful while valid_o = 1. Outside that cycle they hold their last value.
- break_o = frame_err AND (data == 0) AND (parity bit == 0, when parity is enabled).
- busy_o = (state != IDLE).

Optional Feature:
TUART_RX_MAJORITY_EN:
- Defined: every sample point (start, data, parity, stop) takes rx_s at cnt-1, cnt and cnt+1 around the nominal point and uses the 2-of-3 majority. Requires CLK_PER_BIT >= 4. Latency is unchanged, because the decision is registered at cnt+1 and the +1 in the latency formula absorbs it.
- Undefined: a single sample of rx_s at the nominal point. No extra registers.

Test Plan (CLK_PER_BIT = 16, WORD_BITS = 8, STOP_BITS = 1 unless stated):
- PARITY = 0, send 0xA5 → one valid_o pulse, data_o = 0xA5, all error flags 0, valid_o exactly 8 + 9*16 + 1 = 153 cycles after rx_s falls.
- Line low for 4 cycles, then high → no valid_o, busy_o returns to 0 by cycle 10, FSM in IDLE.
- Send 0x3C with stop bit 0, line held low 2 more bit periods → valid_o with data_o = 0x3C, frame_err_o = 1, break_o = 0, busy_o stays 1 until the line goes high.
- PARITY = 1, send 0x07 with parity bit 0 (wrong) → parity_err_o = 1. Resend with parity bit 1 → parity_err_o = 0.
- Line low for 12 bit periods → exactly one valid_o with data_o = 0x00, frame_err_o = 1, break_o = 1, and no further valid_o until the line returns high.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap → three valid_o pulses with the correct data. Assert rst_in for 1 cycle mid-way through a fourth frame → no fourth valid_o, all outputs 0. With TUART_RX_MAJORITY_EN, a 1-cycle glitch at a data bit centre still yields the correct word.
